// File: rtl/ks_pkg.sv
// Shared definitions for the Karplus-Strong string delay line: default widths,
// loop-state encoding and the excitation noise generator constants.
package ks_pkg;

  localparam int ADDR_W_DEF   = 10;
  localparam int SAMPLE_W_DEF = 24;
  localparam int LFSR_W       = 24;

  // Right-shifting Galois taps for x^24 + x^23 + x^22 + x^17 + 1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 24'hE10000;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 24'h5A5A5A;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    RUN    = 2'd1,
    EXCITE = 2'd2
  } ks_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/ks_noise_lfsr.sv
// 24-bit Galois noise source for string excitation; loads the seed on reset and
// advances only while enabled, so it holds its value between plucks.
module ks_noise_lfsr
  import ks_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (en) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/ks_delay_line.sv
// Circular delay line for one Karplus-Strong string: returns each stored sample
// exactly max(period,2) samples later, and on a pluck fills one period with noise.
module ks_delay_line
  import ks_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                SAMPLE_W = SAMPLE_W_DEF,
  parameter logic [LFSR_W-1:0] SEED     = LFSR_SEED
) (
  input  logic                lrck,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   period,
  input  logic                pluck,
  input  logic [3:0]          atten,
  input  logic [SAMPLE_W-1:0] in,
  output logic [SAMPLE_W-1:0] out,
  output logic                busy,
  output ks_state_e           state_dbg,
  output logic [ADDR_W-1:0]   ptr_dbg
);

  // Storage has no reset so it maps onto block RAM; CLEAR does the zeroing.
  logic [SAMPLE_W-1:0] mem [2**ADDR_W];

  ks_state_e                  state;
  logic [ADDR_W-1:0]          ptr;
  logic [ADDR_W-1:0]          clr_cnt;
  logic [ADDR_W-1:0]          exc_cnt;
  logic                       pluck_d;

  logic [ADDR_W-1:0]          p;
  logic [ADDR_W-1:0]          p_last;
  logic                       pluck_rise;
  logic [LFSR_W-1:0]          lfsr;
  logic signed [SAMPLE_W-1:0] noise;
  logic [ADDR_W-1:0]          mem_addr;
  logic [SAMPLE_W-1:0]        mem_wdata;
  logic                       mem_we;

  ks_noise_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (lrck),
    .rst   (rst),
    .en    (state == EXCITE),
    .state (lfsr)
  );

  always_comb begin
    p          = (period < ADDR_W'(2)) ? ADDR_W'(2) : period;
    p_last     = p - ADDR_W'(1);
    pluck_rise = pluck & ~pluck_d;
    noise      = $signed(SAMPLE_W'(lfsr)) >>> atten;
    mem_we     = !rst;
    mem_addr   = ptr;
    mem_wdata  = in;
    if (state == CLEAR) begin
      mem_addr  = clr_cnt;
      mem_wdata = '0;
    end else if (state == EXCITE) begin
      mem_wdata = noise;
    end
  end

  always_ff @(posedge lrck) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge lrck) begin
    if (rst) begin
      state   <= CLEAR;
      ptr     <= '0;
      clr_cnt <= '0;
      exc_cnt <= '0;
      out     <= '0;
      busy    <= 1'b1;
      pluck_d <= 1'b0;
    end else begin
      pluck_d <= pluck;
      case (state)
        CLEAR: begin
          out     <= '0;
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == '1) begin
            ptr   <= '0;
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        default: begin
          // Read-before-write: the old contents leave before this edge's write lands.
          out <= mem[ptr];
          ptr <= (ptr >= p_last) ? '0 : ptr + ADDR_W'(1);
          if (state == RUN) begin
            if (pluck_rise) begin
              state   <= EXCITE;
              exc_cnt <= p_last;
              busy    <= 1'b1;
            end
          end else if (pluck_rise) begin
            exc_cnt <= p_last;
          end else if (exc_cnt == '0) begin
            state <= RUN;
            busy  <= 1'b0;
          end else begin
            exc_cnt <= exc_cnt - ADDR_W'(1);
          end
        end
      endcase
    end
  end

  assign state_dbg = state;
  assign ptr_dbg   = ptr;

endmodule

// File: tb/tb_ks_delay_line.sv
// Directed bench for ks_delay_line: clear sweep, recirculation, pluck excitation,
// retrigger, period shrink and mid-excitation reset, checked by immediate assertions.
module tb_ks_delay_line;
  import ks_pkg::*;

  logic        lrck = 1'b0;
  logic        rst;
  logic [9:0]  period;
  logic        pluck;
  logic [3:0]  atten;
  logic [23:0] in;
  logic [23:0] out;
  logic        busy;
  ks_state_e   state_dbg;
  logic [9:0]  ptr_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [23:0] nz [0:15];
  logic [23:0] seed_tbl [0:4];

  ks_delay_line dut (
    .lrck      (lrck),
    .rst       (rst),
    .period    (period),
    .pluck     (pluck),
    .atten     (atten),
    .in        (in),
    .out       (out),
    .busy      (busy),
    .state_dbg (state_dbg),
    .ptr_dbg   (ptr_dbg)
  );

  always #5 lrck = ~lrck;

  // Advance one sample edge and settle before sampling outputs.
  task automatic tick();
    @(posedge lrck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] shr(input logic [23:0] v, input int sh);
    logic signed [23:0] s;
    s = v;
    return s >>> sh;
  endfunction

  function automatic logic [23:0] ref_step(input logic [23:0] v);
    logic [23:0] r;
    r = {1'b0, v[23:1]};
    if (v[0]) r = r ^ 24'hE10000;
    return r;
  endfunction

  function automatic logic [23:0] val(input int k);
    return 24'h800000 ^ (24'(k) * 24'h010203);
  endfunction

  initial begin
    bit found;
    seed_tbl[0] = 24'h5A5A5A;
    seed_tbl[1] = 24'h2D2D2D;
    seed_tbl[2] = 24'hF79696;
    seed_tbl[3] = 24'h7BCB4B;
    seed_tbl[4] = 24'hDCE5A5;
    nz[0] = 24'h5A5A5A;
    for (int i = 1; i < 16; i++) nz[i] = ref_step(nz[i-1]);

    // Reset and full clear sweep
    rst = 1'b1; period = 10'd8; pluck = 1'b0; atten = 4'd15; in = '0;
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(CLEAR));
    for (int i = 0; i < 1024; i++) begin
      tick();
      chk("clr_out", 32'(out), 32'd0);
      chk("clr_busy", 32'(busy), (i < 1023) ? 32'd1 : 32'd0);
    end
    chk("clr_done_ptr", 32'(ptr_dbg), 32'd0);
    chk("clr_done_state", 32'(state_dbg), 32'(RUN));

    // Recirculation, period 8
    for (int k = 1; k <= 24; k++) begin
      in = val(k);
      tick();
      chk("loop8_out", 32'(out), (k > 8) ? 32'(val(k - 8)) : 32'd0);
    end

    // Pluck at period 5, atten 0, pluck then held high for 20 edges
    period = 10'd5; atten = 4'd0; in = 24'h111111; pluck = 1'b1;
    tick();
    chk("pl5_busy0", 32'(busy), 32'd1);
    chk("pl5_state0", 32'(state_dbg), 32'(EXCITE));
    in = '0;
    for (int e = 1; e <= 19; e++) begin
      tick();
      if (e <= 5) chk("pl5_busy", 32'(busy), (e < 5) ? 32'd1 : 32'd0);
      if (e >= 6 && e <= 10) chk("pl5_noise", 32'(out), 32'(seed_tbl[e - 6]));
      if (e > 5) chk("pl5_single", 32'(busy), 32'd0);
    end
    pluck = 1'b0;
    tick();

    // Retrigger mid-excitation at period 8, atten 4
    period = 10'd8; atten = 4'd4; pluck = 1'b1;
    tick();
    chk("rt_busy0", 32'(busy), 32'd1);
    pluck = 1'b0;
    tick();
    tick();
    pluck = 1'b1;
    tick();
    chk("rt_busy3", 32'(busy), 32'd1);
    for (int f = 4; f <= 19; f++) begin
      tick();
      if (f <= 11) chk("rt_busy", 32'(busy), (f < 11) ? 32'd1 : 32'd0);
      if (f >= 9) chk("rt_noise", 32'(out), 32'(shr(nz[5 + f - 9], 4)));
    end
    pluck = 1'b0;
    in = '0;

    // Period shrink from 16 to 4 with ptr at 9
    period = 10'd16;
    found = 1'b0;
    for (int t = 0; t < 32 && !found; t++) begin
      if (ptr_dbg == 10'd9) found = 1'b1;
      else tick();
    end
    chk("ptr_reach9", 32'(ptr_dbg), 32'd9);
    period = 10'd4;
    tick();
    chk("shrink_wrap", 32'(ptr_dbg), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      in = val(100 + k);
      tick();
      if (k <= 4) chk("shrink_ptr", 32'(ptr_dbg), 32'(k % 4));
      if (k >= 5) chk("loop4_out", 32'(out), 32'(val(100 + k - 4)));
    end

    // Reset during excitation; pluck activity during clear must be ignored
    period = 10'd6; atten = 4'd0; in = '0; pluck = 1'b0;
    tick();
    pluck = 1'b1;
    tick();
    chk("pre_rst_state", 32'(state_dbg), 32'(EXCITE));
    pluck = 1'b0;
    tick();
    tick();
    rst = 1'b1; pluck = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_state", 32'(state_dbg), 32'(CLEAR));
    chk("mid_rst_busy", 32'(busy), 32'd1);
    chk("mid_rst_out", 32'(out), 32'd0);
    for (int i = 0; i < 1024; i++) begin
      pluck = (i >= 1000) ? 1'b1 : ((i % 7) == 0);
      tick();
      chk("clr2_out", 32'(out), 32'd0);
      chk("clr2_busy", 32'(busy), (i < 1023) ? 32'd1 : 32'd0);
    end
    chk("clr2_state", 32'(state_dbg), 32'(RUN));
    tick();
    chk("held_pluck_run", 32'(state_dbg), 32'(RUN));
    chk("held_pluck_busy", 32'(busy), 32'd0);

    // period=1 behaves as 2; LFSR restarted from seed
    period = 10'd1; pluck = 1'b0;
    tick();
    pluck = 1'b1;
    tick();
    chk("p1_busy0", 32'(busy), 32'd1);
    pluck = 1'b0;
    tick();
    chk("p1_busy1", 32'(busy), 32'd1);
    tick();
    chk("p1_busy2", 32'(busy), 32'd0);
    tick();
    chk("p1_noise0", 32'(out), 32'h5A5A5A);
    tick();
    chk("p1_noise1", 32'(out), 32'h2D2D2D);

    // period=0 also behaves as 2
    period = 10'd0;
    for (int k = 1; k <= 6; k++) begin
      in = val(200 + k);
      tick();
      if (k >= 3) chk("p0_loop_out", 32'(out), 32'(val(200 + k - 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
